// File: rtl/cpu_jtag_ocimem_ctrl.sv
// Debug-memory access controller behind the CPU JTAG debug-module wrapper.
// Turns JTAG ocimem strobes into single-word debug-RAM reads/writes with an auto-incrementing address.
module cpu_jtag_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [31:0]       ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] mon_areg,
    output logic              mon_ready,
    output logic              mon_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_CAP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] AREG_INC = ADDR_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] areg_r;
    logic [ADDR_W-1:0] areg_nxt_s;
    logic [31:0]       dreg_r;
    logic [31:0]       dreg_nxt_s;
    logic [31:0]       wdata_r;
    logic [31:0]       wdata_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
    logic              err_clr_s;
    logic              err_set_s;
    logic              wr_r;
    logic              rd_r;
    logic              ready_r;
    logic [1:0]        strobe_cnt_s;
    logic              any_strobe_s;
    logic              unused_jdo_s;

    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

    assign strobe_cnt_s = {1'b0, take_action_ocimem_a} + {1'b0, take_action_ocimem_b}
                        + {1'b0, take_no_action_ocimem_a};
    assign any_strobe_s = (strobe_cnt_s != 2'd0);
    // A strobe while busy is dropped; simultaneous strobes keep only the highest priority one.
    assign err_set_s    = (any_strobe_s && (state_r != ST_IDLE)) || (strobe_cnt_s > 2'd1);

    // Command decode, sequencing and address post-increment.
    always_comb begin
        state_nxt_s = state_r;
        areg_nxt_s  = areg_r;
        dreg_nxt_s  = dreg_r;
        wdata_nxt_s = wdata_r;
        err_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    areg_nxt_s = jdo[ADDR_W+9:10];
                    err_clr_s  = jdo[35];
                    if (jdo[34]) begin
                        state_nxt_s = ST_RD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_nxt_s = jdo[34:3];
                    state_nxt_s = ST_WR;
                end else if (take_no_action_ocimem_a) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                areg_nxt_s  = areg_r + AREG_INC;
                state_nxt_s = ST_IDLE;
            end
            ST_RD: begin
                state_nxt_s = ST_CAP;
            end
            ST_CAP: begin
                dreg_nxt_s  = ram_rdata;
                areg_nxt_s  = areg_r + AREG_INC;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sticky error flag; an accepted clearing address load overrides a same-cycle set.
    always_comb begin
        if (err_clr_s) begin
            err_nxt_s = 1'b0;
        end else if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // State and output registers; RAM strobes are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            areg_r  <= '0;
            dreg_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            wr_r    <= 1'b0;
            rd_r    <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            areg_r  <= areg_nxt_s;
            dreg_r  <= dreg_nxt_s;
            wdata_r <= wdata_nxt_s;
            err_r   <= err_nxt_s;
            wr_r    <= (state_nxt_s == ST_WR);
            rd_r    <= (state_nxt_s == ST_RD);
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    assign ram_addr  = areg_r;
    assign ram_wdata = wdata_r;
    assign ram_wr    = wr_r;
    assign ram_rd    = rd_r;
    assign MonDReg   = dreg_r;
    assign mon_areg  = areg_r;
    assign mon_ready = ready_r;
    assign mon_error = err_r;

endmodule

// File: tb/tb_cpu_jtag_ocimem_ctrl.sv
// Scoreboard bench for cpu_jtag_ocimem_ctrl: directed scenarios, then randomized commands
// against a word-array reference model; a negedge monitor checks RAM accesses and read results.
module tb_cpu_jtag_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = 38'h0;
    logic        act_a = 1'b0;
    logic        act_b = 1'b0;
    logic        noact_a = 1'b0;
    logic [31:0] ram_rdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wr;
    logic        ram_rd;
    logic [31:0] MonDReg;
    logic [7:0]  mon_areg;
    logic        mon_ready;
    logic        mon_error;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [7:0] addr; logic [31:0] data; logic [7:0] next_areg; } rd_t;
    wr_t exp_wr_q[$];
    rd_t exp_rd_q[$];

    // reference model state
    logic [31:0] ref_mem [256];
    logic [7:0]  m_areg;
    logic        m_err;

    logic [31:0] ram_mem [256];

    cpu_jtag_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(act_a), .take_action_ocimem_b(act_b),
        .take_no_action_ocimem_a(noact_a), .ram_rdata(ram_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr(ram_wr), .ram_rd(ram_rd),
        .MonDReg(MonDReg), .mon_areg(mon_areg), .mon_ready(mon_ready), .mon_error(mon_error)
    );

    always #5 clk = ~clk;

    // Debug RAM: synchronous read, garbage on the data bus when not reading.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 32'h0;
            ram_rdata <= $urandom();
        end else begin
            if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
            if (ram_rd) ram_rdata <= ram_mem[ram_addr];
            else ram_rdata <= $urandom();
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [37:0] rnd38();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    // Monitor: pops expectations whenever the DUT accesses the RAM or finishes a read.
    int  rd_due = 0;
    wr_t w;
    always @(negedge clk) begin
        if (reset) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            rd_due = 0;
        end else begin
            if (ram_wr) begin
                chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(w.addr));
                    chk("wr_data", ram_wdata, w.data);
                end
            end
            if (rd_due == 1) begin
                chk("rd_pending", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0) begin
                    chk("MonDReg", MonDReg, exp_rd_q[0].data);
                    chk("rd_next_areg", 32'(mon_areg), 32'(exp_rd_q[0].next_areg));
                    void'(exp_rd_q.pop_front());
                end
            end
            if (rd_due > 0) rd_due--;
            if (ram_rd) begin
                chk("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0) chk("rd_addr", 32'(ram_addr), 32'(exp_rd_q[0].addr));
                rd_due = 2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_read();
        rd_t r;
        r.addr = m_areg;
        r.data = ref_mem[m_areg];
        r.next_areg = m_areg + 8'd1;
        exp_rd_q.push_back(r);
        m_areg = m_areg + 8'd1;
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_ready"}, 32'(mon_ready), 32'd1);
        chk({tag, "_areg"}, 32'(mon_areg), 32'(m_areg));
        chk({tag, "_error"}, 32'(mon_error), 32'(m_err));
    endtask

    task automatic do_load(input logic [7:0] addr, input logic clr, input logic rd, input logic also_wr);
        jdo = rnd38();
        jdo[17:10] = addr;
        jdo[35] = clr;
        jdo[34] = rd;
        act_a = 1'b1;
        act_b = also_wr;
        m_areg = addr;
        if (also_wr) m_err = 1'b1;
        if (clr) m_err = 1'b0;
        if (rd) model_read();
        tick();
        act_a = 1'b0;
        act_b = 1'b0;
        if (rd) begin
            tick();
            tick();
        end
        check_idle("load");
    endtask

    task automatic do_write(input logic [31:0] data);
        wr_t e;
        jdo = rnd38();
        jdo[34:3] = data;
        act_b = 1'b1;
        e.addr = m_areg;
        e.data = data;
        exp_wr_q.push_back(e);
        ref_mem[m_areg] = data;
        m_areg = m_areg + 8'd1;
        tick();
        act_b = 1'b0;
        chk("wr_busy_ready", 32'(mon_ready), 32'd0);
        tick();
        check_idle("write");
    endtask

    task automatic do_read();
        jdo = rnd38();
        noact_a = 1'b1;
        model_read();
        tick();
        noact_a = 1'b0;
        tick();
        tick();
        check_idle("read");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        m_areg = 8'h00;
        m_err = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_ready", 32'(mon_ready), 32'd1);
        chk("rst_areg", 32'(mon_areg), 32'd0);
        chk("rst_dreg", MonDReg, 32'd0);
        chk("rst_error", 32'(mon_error), 32'd0);
        chk("rst_wr", 32'(ram_wr), 32'd0);
        chk("rst_rd", 32'(ram_rd), 32'd0);

        do_load(8'h10, 1'b0, 1'b0, 1'b0);
        do_write(32'hDEADBEEF);
        do_write(32'h12345678);
        chk("after_writes_areg", 32'(mon_areg), 32'h12);
        do_load(8'h10, 1'b0, 1'b1, 1'b0);
        do_read();
        chk("after_reads_areg", 32'(mon_areg), 32'h12);

        do_load(8'hFF, 1'b0, 1'b0, 1'b0);
        do_write(32'hA5A5_0FF0);
        chk("wrap_areg", 32'(mon_areg), 32'h00);

        // read strobe, then a write strobe while busy
        jdo = rnd38();
        noact_a = 1'b1;
        model_read();
        tick();
        noact_a = 1'b0;
        jdo = rnd38();
        act_b = 1'b1;
        m_err = 1'b1;
        tick();
        act_b = 1'b0;
        chk("collide_error", 32'(mon_error), 32'd1);
        tick();
        check_idle("collide");
        do_load(8'h30, 1'b1, 1'b0, 1'b0);

        // reset in the RD cycle of a read
        do_load(8'h20, 1'b0, 1'b0, 1'b0);
        jdo = rnd38();
        noact_a = 1'b1;
        tick();
        noact_a = 1'b0;
        reset = 1'b1;
        tick();
        chk("abort_rd", 32'(ram_rd), 32'd0);
        chk("abort_dreg", MonDReg, 32'd0);
        chk("abort_areg", 32'(mon_areg), 32'd0);
        chk("abort_ready", 32'(mon_ready), 32'd1);
        reset = 1'b0;
        m_areg = 8'h00;
        m_err = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        tick();
        tick();
        chk("abort_dreg_late", MonDReg, 32'd0);
        check_idle("abort");

        for (int n = 0; n < 200; n++) begin
            int op;
            logic [7:0] a;
            op = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 7) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom_range(0, 15));
            if (op < 2) do_load(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 4) == 0));
            else if (op < 6) do_write($urandom());
            else do_read();
        end

        repeat (4) tick();
        chk("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
